// File: rtl/nanov_reg_port_if.sv
// nanov_reg_port_if: host-side request/response bus for the nanoV register port.
//   req_valid/req_ready   request handshake (master -> slave)
//   req_write             1 = write, 0 = read
//   req_addr              register index
//   req_wdata             write data
//   rsp_valid/rsp_ready   response handshake (slave -> master)
//   rsp_rdata             read data (zero for writes and errored reads)
//   rsp_err               illegal target
interface nanov_reg_port_if #(
  parameter int REG_ADDR_BITS = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [REG_ADDR_BITS-1:0] req_addr;
  logic [31:0]              req_wdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/nanov_reg_port.sv
// nanov_reg_port: parallel access port onto the nanoV bit-serial register file.
// A 32-bit read/write request is latched, then transferred one bit per cycle
// (LSB first) in a 32-cycle window aligned to the core's free-running bit
// counter, and finally returned as a parallel response.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     request/response handshake bus
//   grant_i         core is stalled; register file ports may be driven
//   counter_i       core bit counter (0..31, free-running)
//   busy_o          transaction waiting for or performing its transfer
//   next_rs1_o      read address presented one cycle ahead
//   rs1_o, rd_o     read/write address during the transfer
//   wr_en_o         serial write enable
//   data_rd_o       serial write bit
//   data_rs1_i      serial read bit
module nanov_reg_port #(
  parameter int NUM_REGS      = 16,
  parameter int REG_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  nanov_reg_port_if.slave          bus,
  input  logic                     grant_i,
  input  logic [4:0]               counter_i,
  output logic                     busy_o,
  output logic [REG_ADDR_BITS-1:0] next_rs1_o,
  output logic [REG_ADDR_BITS-1:0] rs1_o,
  output logic [REG_ADDR_BITS-1:0] rd_o,
  output logic                     wr_en_o,
  output logic                     data_rd_o,
  input  logic                     data_rs1_i
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_XFER, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [REG_ADDR_BITS-1:0] addr_q,  addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     err_q,   err_d;
  logic [4:0]               bit_q,   bit_d;

  // Request legality. x0 is hardwired zero and x3/x4 hold fixed values in the
  // nanoV register file, so writes to them are refused.
  logic [31:0] addr_ext;
  logic        out_of_range;
  logic        wr_illegal;
  assign addr_ext     = 32'(bus.req_addr);
  assign out_of_range = addr_ext >= 32'(NUM_REGS);
  assign wr_illegal   = (bus.req_addr == REG_ADDR_BITS'(0)) ||
                        (bus.req_addr == REG_ADDR_BITS'(3)) ||
                        (bus.req_addr == REG_ADDR_BITS'(4)) || out_of_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
    end
  end

  // All outputs decode from registered state, so an asynchronous reset
  // removes wr_en_o in the same cycle it is asserted.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bit_d         = bit_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    busy_o        = 1'b0;
    next_rs1_o    = '0;
    rs1_o         = '0;
    rd_o          = '0;
    wr_en_o       = 1'b0;
    data_rd_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = bus.req_write ? wr_illegal : out_of_range;
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        busy_o = 1'b1;
        // The register file reads one cycle ahead, so the address is
        // presented on next_rs1 in the last cycle before bit 0.
        if (counter_i == 5'd31 && grant_i) begin
          next_rs1_o = addr_q;
          bit_d      = '0;
          state_d    = S_XFER;
        end
      end

      S_XFER: begin
        busy_o = 1'b1;
        rs1_o  = addr_q;
        rd_o   = addr_q;
        // Internal bit index drives the window; counter_i is not consulted
        // here and grant_i is not re-checked once the window has started.
        if (bit_q != 5'd31) next_rs1_o = addr_q;
        if (!write_q) begin
          rdata_d[bit_q] = data_rs1_i;
        end else if (!err_q) begin
          wr_en_o   = 1'b1;
          data_rd_o = wdata_q[bit_q];
        end
        bit_d = bit_q + 5'd1;
        if (bit_q == 5'd31) state_d = S_RESP;
      end

      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = (write_q || err_q) ? 32'h0 : rdata_q;
        bus.rsp_err   = err_q;
        if (bus.rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nanov_reg_port.sv
module tb_nanov_reg_port;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          grant = 1'b1;
  logic [4:0]    counter = '0;
  logic          busy, wr_en, data_rd, data_rs1;
  logic [AW-1:0] next_rs1, rs1, rd;

  logic          busy8, wr_en8, data_rd8;
  logic [AW-1:0] next_rs18, rs18, rd8;

  nanov_reg_port_if #(.REG_ADDR_BITS(AW)) bus  ();
  nanov_reg_port_if #(.REG_ADDR_BITS(AW)) bus8 ();

  nanov_reg_port #(.NUM_REGS(16), .REG_ADDR_BITS(AW)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .grant_i(grant), .counter_i(counter),
    .busy_o(busy), .next_rs1_o(next_rs1), .rs1_o(rs1), .rd_o(rd),
    .wr_en_o(wr_en), .data_rd_o(data_rd), .data_rs1_i(data_rs1)
  );

  // Reduced register count: addresses 8..15 are out of range. Its read bit is
  // tied high so an errored read that leaked data would show up.
  nanov_reg_port #(.NUM_REGS(8), .REG_ADDR_BITS(AW)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .grant_i(grant), .counter_i(counter),
    .busy_o(busy8), .next_rs1_o(next_rs18), .rs1_o(rs18), .rd_o(rd8),
    .wr_en_o(wr_en8), .data_rd_o(data_rd8), .data_rs1_i(1'b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) counter <= counter + 5'd1;

  // Bit-serial register file model: bit k of a register is read/written
  // while the core counter equals k.
  function automatic logic [31:0] init_val(int i);
    if (i == 0) return 32'h0;
    if (i == 3) return 32'h0000_1000;
    if (i == 4) return 32'h1000_0000;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  logic [31:0] rf [16];
  logic        rf_load = 1'b1;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
    end else if (wr_en && rd != 4'd0 && rd != 4'd3 && rd != 4'd4) begin
      rf[rd][counter] <= data_rd;
    end
  end
  assign data_rs1 = rf[rs1][counter];

  // Expected register contents, tracked from the requests alone.
  logic [31:0] shadow [16];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Response scoreboard: pop on every response handshake.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  // Write-stream monitor (cumulative counts; tasks take differences).
  int          wr_total = 0, wr_first = 0, wr8_total = 0, rspv_total = 0;
  logic        wr_en_d = 1'b0;
  logic [31:0] wr_bits = '0;
  always @(negedge clk) begin
    if (wr_en) begin
      if (!wr_en_d) wr_first = int'(counter);
      wr_total++;
      wr_bits[counter] = data_rd;
    end
    wr_en_d = wr_en;
    if (wr_en8) wr8_total++;
    if (bus.rsp_valid) rspv_total++;
  end

  // Drive a request (caller is at posedge+1), wait for acceptance and push
  // the expected response. Returns at posedge+1 after the handshake.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    exp_t e;
    int   n;
    e.err   = w && (a == 4'd0 || a == 4'd3 || a == 4'd4);
    e.rdata = (w || e.err) ? 32'h0 : shadow[a];
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready) begin
      sb.push_back(e);
      if (w && !e.err) shadow[a] = d;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_xact(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                         input int nbp, output int arm_wait);
    int          n, armbad, lat, wr0;
    logic        err;
    logic [31:0] r0;
    logic        e0;
    err = w && (a == 4'd0 || a == 4'd3 || a == 4'd4);
    bus.rsp_ready = (nbp == 0);
    send(w, a, d);
    n = 0;
    armbad = 0;
    @(negedge clk);
    while (!(counter == 5'd31 && grant) && n < 200) begin
      if (wr_en || !busy) armbad++;
      n++;
      @(negedge clk);
    end
    arm_wait = n;
    chk("arm_busy_nowr", 32'(armbad), 32'd0);
    chk("next_rs1_entry", 32'(next_rs1), 32'(a));
    wr0 = wr_total;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 100);
    chk("rsp_latency", 32'(lat), 32'd33);
    chk("wr_cycles", 32'(wr_total - wr0), (w && !err) ? 32'd32 : 32'd0);
    if (w && !err) begin
      chk("wr_first_ctr", 32'(wr_first), 32'd0);
      chk("wr_bits", wr_bits, d);
    end
    if (nbp > 0) begin
      r0 = bus.rsp_rdata;
      e0 = bus.rsp_err;
      for (int i = 0; i < nbp; i++) begin
        @(negedge clk);
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rdata", bus.rsp_rdata, r0);
        chk("bp_err", 32'(bus.rsp_err), 32'(e0));
        chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("hs_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Requests to the reduced instance are all illegal.
  task automatic x8(input logic w, input logic [AW-1:0] a);
    int n, w0;
    bus8.req_valid = 1'b1;
    bus8.req_write = w;
    bus8.req_addr  = a;
    bus8.req_wdata = 32'hFFFF_FFFF;
    bus8.rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus8.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("u8_accept", 32'(bus8.req_ready), 32'd1);
    @(posedge clk); #1;
    bus8.req_valid = 1'b0;
    w0 = wr8_total;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.rsp_valid && n < 200);
    chk("u8_lat_min", 32'(n >= 34 && n < 200), 32'd1);
    chk("u8_rsp_err", 32'(bus8.rsp_err), 32'd1);
    chk("u8_rsp_rdata", bus8.rsp_rdata, 32'd0);
    chk("u8_no_wr", 32'(wr8_total - w0), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int aw, n, rv0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus8.req_valid = 1'b0;
    bus8.req_write = 1'b0;
    bus8.req_addr  = '0;
    bus8.req_wdata = '0;
    bus8.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);

    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rf_load = 1'b0;
    chk("post_rst_next_rs1", 32'(next_rs1), 32'd0);
    chk("post_rst_rs1_rd", 32'({rs1, rd}), 32'd0);
    chk("post_rst_rsp", {bus.rsp_rdata[30:0], bus.rsp_err}, 32'd0);

    // Basic write then read back.
    do_xact(1'b1, 4'd5, 32'hDEAD_BEEF, 0, aw);
    do_xact(1'b0, 4'd5, 32'h0, 0, aw);
    // Hardwired registers.
    do_xact(1'b0, 4'd3, 32'h0, 0, aw);
    do_xact(1'b0, 4'd4, 32'h0, 0, aw);
    // Illegal writes keep the full window but never enable the write.
    do_xact(1'b1, 4'd0, 32'h1234_5678, 0, aw);
    do_xact(1'b1, 4'd3, 32'hFFFF_FFFF, 0, aw);
    do_xact(1'b0, 4'd3, 32'h0, 0, aw);
    x8(1'b1, 4'hF);
    x8(1'b0, 4'hA);
    x8(1'b1, 4'd3);

    // Request at counter 10 with grant low until the next lap.
    n = 0;
    while (counter != 5'd10 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    grant = 1'b0;
    fork
      do_xact(1'b1, 4'd6, 32'hCAFE_F00D, 0, aw);
      begin
        while (counter != 5'd31) begin
          @(posedge clk); #1;
        end
        @(posedge clk); #1;
        while (counter != 5'd20) begin
          @(posedge clk); #1;
        end
        grant = 1'b1;
      end
    join
    chk("arm_wait_cycles", 32'(aw), 32'd52);

    // Response backpressure.
    do_xact(1'b0, 4'd6, 32'h0, 5, aw);

    // Reset in the middle of a write to x7.
    send(1'b1, 4'd7, 32'hFFFF_FFFF);
    n = 0;
    @(negedge clk);
    while (!(wr_en && counter == 5'd12) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_found", 32'(wr_en && counter == 5'd12), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    sb.delete();
    shadow[7] = (init_val(7) & ~32'hFFF) | 32'hFFF;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    rv0 = rspv_total;
    repeat (40) @(negedge clk);
    chk("abort_no_rsp", 32'(rspv_total - rv0), 32'd0);
    @(posedge clk); #1;
    do_xact(1'b0, 4'd7, 32'h0, 0, aw);

    // Back-to-back; grant dips mid-window during the read and is ignored.
    do_xact(1'b1, 4'd9, 32'h1234_5678, 0, aw);
    fork
      do_xact(1'b0, 4'd9, 32'h0, 0, aw);
      begin
        int m;
        m = 0;
        while (rs1 != 4'd9 && m < 300) begin
          @(negedge clk);
          m++;
        end
        repeat (3) @(posedge clk);
        #1;
        grant = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        grant = 1'b1;
      end
    join

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
